coef_loader: RTL and testbench
==============================

# coef_loader

Sequencing master for the FIR coefficient write port. It accepts a stream of complex coefficient pairs over a valid/ready handshake and drives the coefficient write bus (PushCoef, CoefAddr, CoefI, CoefQ) into the coefficient register bank. Addresses run 1..NUM_TAPS in order, one write per accepted pair. The block sits between the host/config interface and the coefficient demux. It adds start/abort control, a stall timeout and completion/error status.

## Interface
- NUM_TAPS, 15: coefficient pairs per load; addresses 1..NUM_TAPS.
- COEF_W, 27: signed coefficient width, I and Q each.
- ADDR_W, 5: CoefAddr width.
- TIMEOUT, 1023: max consecutive stalled LOAD cycles before error; range 1..2^16-1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- Abort  in  1  cancel an in-progress load.
- InValid  in  1  source has a coefficient pair.
- InReady  out  1  loader accepts the pair this cycle (combinational).
- InI / InQ  in  COEF_W each  signed coefficient, real / imaginary.
- PushCoef  out  1  write strobe to the coefficient bank (registered).
- CoefAddr  out  ADDR_W  write address, 1-based (registered).
- CoefI / CoefQ  out  COEF_W each  write data (registered).
- Busy  out  1  high while in LOAD.
- Done  out  1  one-cycle pulse: full set written.
- Error  out  1  one-cycle pulse: load terminated by timeout.

## Operation
- States: IDLE and LOAD.
- IDLE to LOAD on Start && !Abort. The tap counter loads 1 and the stall counter loads 0.
- LOAD: InReady = !Abort. An accept is InValid && InReady.
  - On an accept, the next cycle shows PushCoef=1, CoefAddr=tap counter, and CoefI/CoefQ = the accepted InI/InQ.
  - The tap counter then increments and the stall counter clears.
- Accept with tap counter == NUM_TAPS: go to IDLE and assert Done in the same cycle as the final PushCoef.
- No accept in LOAD: the stall counter increments. When it reaches TIMEOUT, go to IDLE and pulse Error the next cycle. No further pushes occur.
- Abort in LOAD: no accept that cycle; go to IDLE with no Done and no Error. Registers already written stay written.
- Start while in LOAD is ignored.
- Start and Abort in the same IDLE cycle: Abort wins and the block stays IDLE.
- Abort in IDLE has no effect.
- PushCoef is low in every cycle without a preceding accept. CoefAddr/CoefI/CoefQ hold their last value when PushCoef is low.
- Address 0 and addresses above NUM_TAPS are never driven with PushCoef=1.
- Data passes through unchanged: no rounding or sign manipulation.

## Timing
- Reset values: state IDLE; PushCoef, Busy, Done and Error are 0; CoefAddr, CoefI and CoefQ are 0; internal counters are 0.
- Reset mid-load returns to IDLE immediately (asynchronous) and no partial push completes. The bank's own reset clears stored coefficients.
- Start sampled at edge t gives Busy=1 and InReady=1 (absent Abort) in cycle t+1.
- Latency is 1 cycle from accept edge to PushCoef.
- Throughput is one pair per cycle. A full back-to-back load takes NUM_TAPS accept cycles.
- Busy falls in the cycle Done rises.
- Done, Error and Abort completion are mutually exclusive per load.
- The earliest next Start is the cycle Done or Error is visible.
- TIMEOUT counts only cycles in LOAD without an accept. Error is visible TIMEOUT+1 cycles after the last accept, or after LOAD entry if nothing was accepted.

## Structure
- Shared package fir_pkg holds:
  - COEF_W, ADDR_W and NUM_TAPS constants;
  - typedef coef_t (signed [COEF_W-1:0]);
  - a complex pair struct {coef_t re, im};
  - enum loader_state_t {IDLE, LOAD}.
- Single flat module with no sub-modules. The stall counter width is derived from TIMEOUT with $clog2.

## Test plan
- Full load: Start, then 15 back-to-back pairs I=k*1000, Q=-k (k=1..15). Expect 15 consecutive PushCoef cycles with CoefAddr 1..15 and matching data, Done in the cycle of addr 15, and Busy low afterwards.
- Throttled source: InValid on alternate cycles with TIMEOUT=4. Expect pushes every other cycle, addresses contiguous, no Error, and Done after 15 pushes.
- Timeout: TIMEOUT=4, 3 pairs then InValid held low. Expect pushes at addr 1..3, Error pulse exactly 5 cycles after the 3rd accept, IDLE, and no addr 4.
- Abort: assert Abort in the cycle of the 6th InValid. Expect InReady=0 that cycle, only addr 1..5 pushed, no Done/Error, and a new Start restarting at addr 1.
- Start during LOAD and Start+Abort in IDLE: both ignored. Expect the address sequence unperturbed and Busy staying 0 respectively.
- Async Reset asserted mid-load, with Clk stalled: outputs go to 0 at once. After release, a Start reloads from addr 1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR constants and types for the coefficient path.
package fir_pkg;
  localparam int COEF_W   = 27;
  localparam int ADDR_W   = 5;
  localparam int NUM_TAPS = 15;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t re;
    coef_t im;
  } coef_pair_t;

  typedef enum logic {IDLE, LOAD} loader_state_t;
endpackage

// File: rtl/coef_loader_if.sv
// Coefficient stream input plus coefficient bank write bus.
interface coef_loader_if;
  import fir_pkg::*;

  logic              in_valid;
  logic              in_ready;
  coef_t             in_i;
  coef_t             in_q;
  logic              push_coef;
  logic [ADDR_W-1:0] coef_addr;
  coef_t             coef_i;
  coef_t             coef_q;

  // master is the loader: it consumes the stream and drives the bank
  modport master (input in_valid, in_i, in_q,
                  output in_ready, push_coef, coef_addr, coef_i, coef_q);
  modport slave  (output in_valid, in_i, in_q,
                  input in_ready, push_coef, coef_addr, coef_i, coef_q);
endinterface

// File: rtl/coef_loader.sv
// Sequences a stream of complex coefficient pairs into bank addresses
// 1..NUM_TAPS with start/abort control, stall timeout and status pulses.
module coef_loader
  import fir_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  coef_loader_if.master bus,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  loader_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  tap_q, tap_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [STALL_W-1:0] stall_inc;
  logic               push_q, push_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  coef_pair_t         data_q, data_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               in_ready;
  logic               accept;

  assign in_ready  = (state_q == LOAD) && !abort_i;
  assign accept    = in_ready && bus.in_valid;
  assign stall_inc = stall_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    stall_d = stall_q;
    push_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = LOAD;
          tap_d   = ADDR_W'(1);
          stall_d = '0;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept) begin
          push_d  = 1'b1;
          addr_d  = tap_q;
          data_d  = '{re: bus.in_i, im: bus.in_q};
          stall_d = '0;
          if (tap_q == ADDR_W'(NUM_TAPS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end else if (stall_inc == STALL_W'(TIMEOUT)) begin
          state_d = IDLE;
          error_d = 1'b1;
          stall_d = '0;
        end else begin
          stall_d = stall_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      stall_q <= '0;
      push_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      stall_q <= stall_d;
      push_q  <= push_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.push_coef = push_q;
  assign bus.coef_addr = addr_q;
  assign bus.coef_i    = data_q.re;
  assign bus.coef_q    = data_q.im;
  assign busy_o        = (state_q == LOAD);
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_coef_loader.sv
// Randomized scoreboard bench for coef_loader with a transaction-level model.
module tb_coef_loader;
  import fir_pkg::*;

  localparam int TMO = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    coef_t             i;
    coef_t             q;
    logic              done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, error;

  coef_loader_if bus ();

  coef_loader #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .abort_i (abort),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done),
    .error_o (error)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   err_q[$];

  // Model: a load is "active", the next pair goes to m_next, and a load with
  // no accepted pair times out at m_deadline (TMO+1 cycles after last activity).
  bit m_load = 0;
  int m_next = 0;
  int m_deadline = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every bank write and status pulse against the queues.
  always @(negedge clk) begin
    if (bus.push_coef === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 64'(bus.coef_addr), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("push_addr", 64'(bus.coef_addr), 64'(e.addr));
        chk("push_i", 64'(bus.coef_i), 64'(e.i));
        chk("push_q", 64'(bus.coef_q), 64'(e.q));
        chk("push_done", 64'(done), 64'(e.done));
      end
    end else if (done === 1'b1) begin
      chk("done_without_push", 64'(done), 64'd0);
    end
    if (error === 1'b1) begin
      if (err_q.size() == 0) chk("unexpected_error", 64'(cyc), 64'hDEAD);
      else chk("error_cycle", 64'(cyc), 64'(err_q.pop_front()));
    end
  end

  task automatic drive(input bit st, input bit ab, input bit vl, input coef_t di, input coef_t dq);
    exp_t e;
    start = st;
    abort = ab;
    bus.in_valid = vl;
    bus.in_i = di;
    bus.in_q = dq;
    #1;
    chk("busy", 64'(busy), 64'(m_load));
    chk("in_ready", 64'(bus.in_ready), 64'(m_load && !ab));
    if (!m_load) begin
      if (st && !ab) begin
        m_load = 1;
        m_next = 1;
        m_deadline = cyc + TMO + 1;
      end
    end else if (ab) begin
      m_load = 0;
    end else if (vl) begin
      e.addr = ADDR_W'(m_next);
      e.i = di;
      e.q = dq;
      e.done = (m_next == NUM_TAPS);
      exp_q.push_back(e);
      if (m_next == NUM_TAPS) m_load = 0;
      m_next++;
      m_deadline = cyc + TMO + 1;
    end else if (cyc + 1 == m_deadline) begin
      m_load = 0;
      err_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rdrive(input bit st, input bit ab, input bit vl);
    drive(st, ab, vl, coef_t'($urandom), coef_t'($urandom));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rdrive(0, 0, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    #2;
    chk("rst_push", 64'(bus.push_coef), 64'd0);
    chk("rst_addr", 64'(bus.coef_addr), 64'd0);
    chk("rst_i", 64'(bus.coef_i), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full back-to-back load with directed data
    rdrive(1, 0, 0);
    for (int k = 1; k <= NUM_TAPS; k++) drive(0, 0, 1, coef_t'(k * 1000), coef_t'(-k));
    idle(3);

    // throttled source: valid every other cycle
    rdrive(1, 0, 0);
    for (int k = 0; k < 2 * NUM_TAPS; k++) rdrive(0, 0, k[0]);
    idle(3);

    // timeout after three pairs
    rdrive(1, 0, 0);
    for (int k = 0; k < 3; k++) rdrive(0, 0, 1);
    idle(8);

    // abort on sixth pair, then restart
    rdrive(1, 0, 0);
    for (int k = 0; k < 5; k++) rdrive(0, 0, 1);
    rdrive(0, 1, 1);
    idle(3);
    rdrive(1, 0, 0);
    for (int k = 0; k < NUM_TAPS; k++) rdrive(0, 0, 1);
    idle(2);

    // start during load, start+abort and abort alone in idle
    rdrive(1, 0, 0);
    for (int k = 0; k < NUM_TAPS; k++) rdrive(k == 7, 0, 1);
    rdrive(1, 1, 0);
    rdrive(0, 1, 1);
    idle(2);

    // randomized traffic, second pass with a sparser source to provoke timeouts
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 400; k++) begin
        bit st, ab, vl;
        if (!m_load) begin
          st = ($urandom_range(0, 3) == 0);
          ab = ($urandom_range(0, 9) == 0);
        end else begin
          st = ($urandom_range(0, 19) == 0);
          ab = ($urandom_range(0, 59) == 0);
        end
        vl = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        rdrive(st, ab, vl);
      end
      idle(TMO + 2);
    end

    // asynchronous reset mid-load with the clock stopped
    rdrive(1, 0, 0);
    for (int k = 0; k < 4; k++) rdrive(0, 0, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst = 1'b1;
    #2;
    chk("arst_push", 64'(bus.push_coef), 64'd0);
    chk("arst_addr", 64'(bus.coef_addr), 64'd0);
    chk("arst_i", 64'(bus.coef_i), 64'd0);
    chk("arst_q", 64'(bus.coef_q), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd0);
    m_load = 0;
    #3;
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    rdrive(1, 0, 0);
    for (int k = 0; k < NUM_TAPS; k++) rdrive(0, 0, 1);
    idle(TMO + 3);

    chk("pending_pushes", 64'(exp_q.size()), 64'd0);
    chk("pending_errors", 64'(err_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
